// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte-stream
// requesters. A grant is held for a whole message, subject to a burst limit and a stall timeout.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     grant,
    output logic                tx_start,
    output logic [7:0]          tx_din,
    input  logic                tx_done_tick,
    output logic                busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [7:0]        burst_q, burst_d;
    logic [15:0]       idle_q, idle_d;
    logic              last_q, last_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_din_q, tx_din_d;
    logic [NREQ-1:0]   grant_q, grant_d;

    logic [PW-1:0]     sel;
    logic              sel_vld;
    logic [PW:0]       cand;
    logic [PW-1:0]     acc_idx;
    logic              accept;

    // Search ptr+1, ptr+2, ... mod NREQ; iterating downwards lets the nearest hit win.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
            if (req_valid[cand[PW-1:0]]) begin
                sel     = cand[PW-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= PW'(NREQ-1);
            gidx_q     <= '0;
            burst_q    <= '0;
            idle_q     <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            burst_q    <= burst_d;
            idle_q     <= idle_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
            grant_q    <= grant_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        burst_d    = burst_q;
        idle_d     = idle_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_din_d   = tx_din_q;
        grant_d    = grant_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    gidx_d       = sel;
                    burst_d      = 8'd1;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                end
            end
            S_WAIT: begin
                if (tx_done_tick) begin
                    if (last_q || burst_q == 8'(MAX_BURST)) begin
                        state_d = S_IDLE;
                        ptr_d   = gidx_q;
                        grant_d = '0;
                    end else begin
                        state_d = S_HOLD;
                        idle_d  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    burst_d = burst_q + 8'd1;
                end else if (idle_q == 16'(HOLD_TIMEOUT-1)) begin
                    state_d = S_IDLE;
                    ptr_d   = gidx_q;
                    grant_d = '0;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d    = S_WAIT;
            tx_start_d = 1'b1;
            tx_din_d   = req_data[{acc_idx, 3'b000} +: 8];
            last_d     = req_last[acc_idx];
        end
    end

    // req_ready is combinational, so it is gated by reset_n to clear the moment reset asserts.
    always_comb begin
        acc_idx   = (state_q == S_HOLD) ? gidx_q : sel;
        accept    = ((state_q == S_IDLE) && sel_vld) ||
                    ((state_q == S_HOLD) && req_valid[gidx_q]);
        req_ready = '0;
        if (accept && reset_n) req_ready[acc_idx] = 1'b1;
        busy      = (state_q != S_IDLE);
    end

    assign grant    = grant_q;
    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration table, directed message/burst/timeout/reset
// sequences, and randomized traffic checked every cycle against an ownership model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     req_valid, req_last, req_ready, grant;
    logic [8*N-1:0]   req_data;
    logic             tx_start, tx_done_tick, busy;
    logic [7:0]       tx_din;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NREQ(N), .MAX_BURST(MB), .HOLD_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_start(tx_start),
        .tx_din(tx_din), .tx_done_tick(tx_done_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    // requester byte queues and transmitter emulation
    logic [7:0]   qd[N][$];
    bit           ql[N][$];
    int           off_t[N];
    bit           rnd_en = 0, tx_hold = 0;
    int           tx_cnt = 0;
    logic [N-1:0] pend_pop = '0;
    int           ord[$];

    // reference: who owns the transmitter and what it is waiting for
    int         m_own = -1, m_cnt = 0, m_idle = 0, m_ptr = N-1;
    bit         m_wait = 0, m_last = 0, m_start = 0;
    logic [7:0] m_din = '0;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] er;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit l);
        qd[i].push_back(d);
        ql[i].push_back(l);
    endtask

    task automatic push_msg(input int i, input int len);
        for (int j = 0; j < len; j++) push(i, 8'($urandom_range(0, 255)), j == len-1);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tx_hold = 0;
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
            off_t[i] = 0;
        end
        ord.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step();
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (qd[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while ((pending() || busy) && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_drain_timeout"}, 32'(n < budget), 1);
    endtask

    task automatic chk_order(input string nm, input int exp[$]);
        chk({nm, "_count"}, ord.size(), exp.size());
        for (int i = 0; i < exp.size() && i < ord.size(); i++) chk({nm, "_order"}, ord[i], exp[i]);
    endtask

    // input driver: consumes accepted bytes, shapes req_valid, emulates tx_done_tick
    initial begin
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tx_done_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pend_pop[i] && qd[i].size() > 0) begin
                    void'(qd[i].pop_front());
                    void'(ql[i].pop_front());
                end
                if (rnd_en) begin
                    if (off_t[i] > 0) off_t[i]--;
                    else if ($urandom_range(0, 9) == 0) off_t[i] = $urandom_range(1, 12);
                    if (qd[i].size() < 8 && $urandom_range(0, 19) == 0) push_msg(i, $urandom_range(1, 6));
                end
                req_valid[i]     = (qd[i].size() > 0) && (off_t[i] == 0);
                req_data[8*i+:8] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
                req_last[i]      = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
            end
            pend_pop = '0;
            tx_done_tick = reset_n && !tx_hold &&
                           ((tx_cnt == 1) || (rnd_en && !m_wait && $urandom_range(0, 7) == 0));
        end
    end

    // reference model: compares every cycle, then advances on the coming edge
    initial begin : model
        int w;
        int idx;
        logic [N-1:0] er;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_own = -1; m_wait = 0; m_cnt = 0; m_last = 0; m_idle = 0;
                m_ptr = N-1; m_start = 0; m_din = '0; tx_cnt = 0; pend_pop = '0;
            end else begin
                w = -1;
                if (m_own < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (w < 0 && req_valid[idx]) w = idx;
                    end
                end else if (!m_wait && req_valid[m_own]) begin
                    w = m_own;
                end
                er = '0;
                if (w >= 0) er[w] = 1'b1;
                chk("ready", 32'(req_ready), 32'(er));
                chk("grant", 32'(grant), (m_own < 0) ? 0 : (1 << m_own));
                chk("busy", 32'(busy), 32'(m_own >= 0));
                chk("tx_start", 32'(tx_start), 32'(m_start));
                chk("tx_din", 32'(tx_din), 32'(m_din));
                for (int i = 0; i < N; i++) if (req_ready[i]) ord.push_back(i);
                pend_pop = er;
                if (w >= 0) begin
                    m_cnt   = (m_own < 0) ? 1 : m_cnt + 1;
                    m_own   = w;
                    m_wait  = 1;
                    m_last  = req_last[w];
                    m_start = 1;
                    m_din   = req_data[8*w+:8];
                end else begin
                    m_start = 0;
                    if (m_own >= 0 && m_wait) begin
                        if (tx_done_tick) begin
                            if (m_last || m_cnt == MB) begin
                                m_ptr = m_own;
                                m_own = -1;
                            end
                            m_wait = 0;
                            m_idle = 0;
                        end
                    end else if (m_own >= 0) begin
                        if (m_idle == TO-1) begin
                            m_ptr = m_own;
                            m_own = -1;
                        end else begin
                            m_idle++;
                        end
                    end
                end
                if (!tx_hold) begin
                    if (w >= 0) tx_cnt = $urandom_range(2, 7);
                    else if (tx_cnt > 0) tx_cnt--;
                end
            end
        end
    end

    initial begin : stim
        int n;
        int eq[$];
        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b0110, 4'b0010};
        tbl[2] = '{4'b1100, 4'b0100};
        tbl[3] = '{4'b1000, 4'b1000};
        tbl[4] = '{4'b1111, 4'b0001};
        tbl[5] = '{4'b0000, 4'b0000};
        tbl[6] = '{4'b1010, 4'b0010};
        tbl[7] = '{4'b0101, 4'b0001};

        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_din", 32'(tx_din), 0);
        chk("rst_ready", 32'(req_ready), 0);

        // first arbitration out of reset: requester 0 has top priority
        for (int t = 0; t < 8; t++) begin
            do_reset();
            for (int i = 0; i < N; i++) if (tbl[t].v[i]) push(i, 8'(8'h40 + i), 1'b1);
            step();
            chk("arb_table", 32'(req_ready), 32'(tbl[t].er));
        end

        // single request
        do_reset();
        push(2, 8'h5A, 1'b1);
        step();
        chk("sr_ready", 32'(req_ready), 32'h4);
        chk("sr_start_early", 32'(tx_start), 0);
        step();
        chk("sr_start", 32'(tx_start), 1);
        chk("sr_din", 32'(tx_din), 32'h5A);
        chk("sr_grant", 32'(grant), 32'h4);
        chk("sr_ready_off", 32'(req_ready), 0);
        n = 0;
        while (!tx_done_tick && n < 20) begin step(); n++; end
        chk("sr_tick_timeout", 32'(n < 20), 1);
        chk("sr_busy_at_tick", 32'(busy), 1);
        step();
        chk("sr_busy_after", 32'(busy), 0);
        chk("sr_grant_after", 32'(grant), 0);

        // fairness
        do_reset();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
        wait_drain("fair", 500);
        eq = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_order("fair", eq);

        // message hold
        do_reset();
        push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
        step();
        push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
        wait_drain("hold", 500);
        eq = '{1, 1, 1, 0, 0};
        chk_order("hold", eq);

        // burst limit
        do_reset();
        for (int j = 0; j < 10; j++) push(0, 8'(8'h80 + j), j == 9);
        push(1, 8'hB1, 1'b1);
        wait_drain("burst", 1000);
        eq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        chk_order("burst", eq);

        // stall timeout: tick -> 8 HOLD cycles -> IDLE accepts requester 0
        do_reset();
        push(3, 8'h31, 1'b0);
        step();
        push(0, 8'h01, 1'b1);
        n = 0;
        while (!tx_done_tick && n < 20) begin step(); n++; end
        chk("to_tick_timeout", 32'(n < 20), 1);
        n = 0;
        do begin step(); n++; end while (!req_ready[0] && n < 40);
        chk("to_release_cycles", n, 9);
        push(3, 8'h32, 1'b1);
        wait_drain("to", 500);
        eq = '{3, 0, 3};
        chk_order("to", eq);

        // reset during WAIT
        do_reset();
        tx_hold = 1;
        push(2, 8'hC3, 1'b1);
        step();
        push(0, 8'h0F, 1'b1);
        step();
        step();
        chk("rm_in_wait", 32'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rm_tx_start", 32'(tx_start), 0);
        chk("rm_grant", 32'(grant), 0);
        chk("rm_ready", 32'(req_ready), 0);
        chk("rm_busy", 32'(busy), 0);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rm_no_start", 32'(tx_start), 0);
        end
        push(3, 8'h33, 1'b1);
        push(0, 8'h00, 1'b1);
        wait_drain("rm", 500);
        eq = '{0, 3};
        chk_order("rm", eq);

        // randomized traffic, checked by the model every cycle
        do_reset();
        rnd_en = 1;
        repeat (4000) @(posedge clk);
        #2;
        rnd_en = 0;
        for (int i = 0; i < N; i++) off_t[i] = 0;
        wait_drain("rnd", 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among NREQ byte-stream requesters (CPU MMIO port, debug/trace port, etc.). It accepts one byte at a time from the granted requester and drives the transmitter's tx_start/din handshake. It waits for tx_done_tick before issuing the next byte. A grant is held across a multi-byte message (until req_last) so messages are never interleaved, subject to a burst limit and a stall timeout.

## Interface
- NREQ, 4: number of requesters (2..8).
- MAX_BURST, 16: max bytes sent under one grant before forced re-arbitration (1..255).
- HOLD_TIMEOUT, 1024: clk cycles a granted requester may leave req_valid low mid-message before the grant is revoked (2..65535).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester byte available.
- req_data  in  8*NREQ  byte of requester i at [8*i+7:8*i].
- req_last  in  NREQ  byte is last of its message.
- req_ready  out  NREQ  one-hot pulse, byte of that requester accepted this cycle.
- grant  out  NREQ  one-hot registered, current owner (0 when idle).
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_din  out  8  byte to transmitter, registered, stable from tx_start until next accept.
- tx_done_tick  in  1  transmitter stop-bit complete.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT, HOLD.
- IDLE: grant = 0.
  - If any req_valid, select g by round-robin, searching ptr+1, ptr+2, … mod NREQ.
  - Accept: req_ready[g]=1 in the same cycle (combinational on req_valid), tx_din<=req_data[g], tx_start<=1, grant<=onehot(g), burst_cnt<=1, last_q<=req_last[g]; go to WAIT.
- WAIT: tx_start clears after exactly one cycle. Await tx_done_tick.
  - On tick with last_q=1 or burst_cnt==MAX_BURST: go to IDLE, ptr<=g, grant<=0.
  - On tick otherwise: go to HOLD, idle_cnt<=0.
- HOLD: grant stays onehot(g). Requests from any other requester are ignored.
  - If req_valid[g]: accept as in IDLE (burst_cnt+1, last_q<=req_last[g]); go to WAIT.
  - Else idle_cnt+1. When idle_cnt reaches HOLD_TIMEOUT-1: go to IDLE, ptr<=g, grant<=0.
- Exactly one requester is accepted per tx_start. req_ready is never asserted outside an accept cycle.
- tx_done_tick is ignored in IDLE and HOLD.
- Widths: burst_cnt is 8 bits, idle_cnt is 16 bits, ptr is clog2(NREQ) bits with modulo-NREQ wrap. Counters never wrap; they are compared for equality and reset on use.
- Reset values: ptr=NREQ-1 (requester 0 has first priority), state IDLE, tx_start=0, tx_din=0, grant=0, req_ready=0, busy=0, counters 0.

## Timing
- Accept from IDLE: req_valid[g] high at cycle t gives req_ready[g] at t and tx_start/tx_din at t+1.
- Back-to-back bytes within a message:
  - tx_done_tick at cycle t gives HOLD at t+1.
  - If req_valid[g] is high at t+1, then req_ready at t+1 and tx_start at t+2.
  - The transmitter is back in idle by t+1, so no start pulse is lost.
- Release: tx_done_tick with last_q at t gives IDLE at t+1. A new grant is possible at t+1, with tx_start at t+2.
- Simultaneous requests in IDLE: only the round-robin winner gets req_ready. The others stay pending with no ready.
- MAX_BURST=1 gives pure per-byte round-robin.
- Reset asserted mid-operation: all outputs clear immediately (asynchronously). No tx_start is issued after reset_n deasserts until a fresh req_valid arrives. The transmitter shares this reset, so no partial frame is completed.

## Test plan
- Single request:
  - Stimulus: req_valid[2]=1, data 0x5A, last=1.
  - Required: req_ready[2] same cycle; tx_start one cycle later with tx_din=0x5A; busy until 1 cycle after tx_done_tick; then grant=0.
- Fairness:
  - Stimulus: all 4 requesters continuously valid with single-byte messages (last=1).
  - Required: service order 0,1,2,3,0,1; no requester served twice in a row.
- Message hold:
  - Stimulus: requester 1 sends a 3-byte message 0x11,0x22,0x33 (last on 0x33) while requester 0 is valid throughout.
  - Required: all three bytes from requester 1 go out consecutively; requester 0 is granted next.
- Burst limit:
  - Stimulus: MAX_BURST=4; requester 0 sends a 10-byte message; requester 1 is valid.
  - Required: after 4 bytes, grant moves to requester 1; requester 0 resumes afterwards.
- Stall timeout:
  - Stimulus: HOLD_TIMEOUT=8; requester 3 drops req_valid mid-message.
  - Required: grant released 8 cycles after entering HOLD; the waiting requester is then accepted.
- Reset mid-frame:
  - Stimulus: pull reset_n low during WAIT.
  - Required: tx_start, grant, req_ready and busy all read 0 immediately. After release, requester 0 has priority.
